// File: rtl/lane_gearbox.sv
// Per-lane width converter: buffers up to two LANE_WIDTH codewords and emits each
// as RATIO consecutive OUT_WIDTH slices, LSB slice first, with no bubble between words.
module lane_gearbox #(
  parameter int LANE_WIDTH = 1360,
  parameter int OUT_WIDTH  = 136
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [LANE_WIDTH-1:0] i_lane,
  input  logic                  i_sync,
  output logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_sync,
  output logic                  o_overflow,
  output logic [1:0]            o_level
);

  localparam int RATIO = LANE_WIDTH / OUT_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (LANE_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
      $fatal(1, "lane_gearbox: LANE_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                       state, state_d;
  logic [CW-1:0]                cnt, cnt_d;
  logic                         wr_ptr, rd_ptr;
  logic [LANE_WIDTH-1:0]        mem_data [2];
  logic [1:0]                   mem_sync;
  logic                         pop_last, push, ld;
  logic [LANE_WIDTH-1:0]        src_data;
  logic                         src_sync;
  logic [RATIO-1:0][OUT_WIDTH-1:0] src_slices;

  assign o_valid  = (state == EMIT);
  assign pop_last = o_valid && (cnt == CW'(RATIO - 1));
  assign o_ready  = (o_level != 2'd2) || pop_last;
  assign push     = i_valid && o_ready;

  // Next slice source: current word, the other buffered word, or a word being
  // accepted into the just-freed slot (bypassed so the output stays gap-free).
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ld       = 1'b0;
    src_data = mem_data[rd_ptr];
    src_sync = mem_sync[rd_ptr];
    case (state)
      IDLE: begin
        if (o_level != 2'd0) begin
          state_d = EMIT;
          cnt_d   = '0;
          ld      = 1'b1;
        end
      end
      EMIT: begin
        if (!pop_last) begin
          cnt_d = cnt + CW'(1);
          ld    = 1'b1;
        end else if (o_level == 2'd2) begin
          cnt_d    = '0;
          ld       = 1'b1;
          src_data = mem_data[~rd_ptr];
          src_sync = mem_sync[~rd_ptr];
        end else if (push) begin
          cnt_d    = '0;
          ld       = 1'b1;
          src_data = i_lane;
          src_sync = i_sync;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign src_slices = src_data[RATIO*OUT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Storage has no reset: contents are only observed once level says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= i_lane;
      mem_sync[wr_ptr] <= i_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      o_level    <= 2'd0;
      o_data     <= '0;
      o_sof      <= 1'b0;
      o_sync     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (push)     wr_ptr <= ~wr_ptr;
      if (pop_last) rd_ptr <= ~rd_ptr;
      case ({push, pop_last})
        2'b10:   o_level <= o_level + 2'd1;
        2'b01:   o_level <= o_level - 2'd1;
        default: o_level <= o_level;
      endcase
      if (ld) o_data <= src_slices[cnt_d];
      o_sof  <= ld && (cnt_d == '0);
      o_sync <= ld && (cnt_d == '0) && src_sync;
      if (i_valid && !o_ready) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_gearbox.sv
// Directed bench for lane_gearbox: one task per scenario, expected values hand-derived.
module tb_lane_gearbox;
  localparam int LW = 1360;
  localparam int OW = 136;

  logic          clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_sync = 1'b0;
  logic [LW-1:0] i_lane = '0;
  logic          o_ready, o_valid, o_sof, o_sync, o_overflow;
  logic [OW-1:0] o_data;
  logic [1:0]    o_level;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lane_gearbox #(.LANE_WIDTH(LW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_lane(i_lane), .i_sync(i_sync),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof),
    .o_sync(o_sync), .o_overflow(o_overflow), .o_level(o_level)
  );

  // Word whose slice k holds base+k.
  function automatic logic [LW-1:0] mk(input int base);
    logic [LW-1:0] w;
    w = '0;
    for (int k = 0; k < 10; k++) w[k*OW +: OW] = OW'(base + k);
    return w;
  endfunction

  task automatic apply_reset;
    rst = 1'b1; i_valid = 1'b0; i_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Observed vector layout: {overflow, valid, sof, sync, level[1:0], data}
  task automatic test_reset;
    logic [OW+5:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset outputs: got %h expected 0", got); end
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", o_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [OW+5:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 11; c++) begin
      i_valid = (c == 0); i_lane = mk(1); i_sync = 1'b1;
      @(posedge clk); #1;
      if (c == 0)       exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, OW'(0)};
      else if (c <= 10) exp = {1'b0, 1'b1, (c == 1), (c == 1), 2'd1, OW'(c)};
      else              exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, OW'(10)};
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL single c=%0d: got %h expected %h", c, got, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [OW+5:0] got, exp;
    int base [3];
    int w, k;
    base = '{32'h100, 32'h200, 32'h300};
    apply_reset();
    for (int c = 0; c <= 31; c++) begin
      i_valid = (c == 0) || (c == 11) || (c == 21);
      i_lane  = mk(base[(c == 0) ? 0 : (c == 11) ? 1 : 2]);
      i_sync  = (c == 11);
      @(posedge clk); #1;
      w = (c - 1) / 10; k = (c - 1) % 10;
      if (c == 0)       exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, OW'(0)};
      else if (c <= 30) exp = {1'b0, 1'b1, (k == 0), (k == 0 && w == 1), 2'd1, OW'(base[w] + k)};
      else              exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, OW'(32'h309)};
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL back_to_back c=%0d: got %h expected %h", c, got, exp); end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_burst_fill;
    logic [OW+5:0] got, exp;
    logic [1:0] lvl;
    int base [3];
    int w, k;
    base = '{32'h10, 32'h20, 32'h30};
    apply_reset();
    for (int c = 0; c <= 21; c++) begin
      i_valid = (c <= 2); i_lane = mk(base[(c <= 2) ? c : 0]); i_sync = 1'b0;
      #1;
      if (c <= 2) begin
        n_tests++;
        if (o_ready !== (c < 2)) begin n_fail++; $display("FAIL burst ready c=%0d: got %b expected %b", c, o_ready, (c < 2)); end
      end
      @(posedge clk); #1;
      w = (c - 1) / 10; k = (c - 1) % 10;
      lvl = (c == 0) ? 2'd1 : (c <= 10) ? 2'd2 : (c <= 20) ? 2'd1 : 2'd0;
      if (c == 0)       exp = {1'b0, 1'b0, 1'b0, 1'b0, lvl, OW'(0)};
      else if (c <= 20) exp = {(c >= 2), 1'b1, (k == 0), 1'b0, lvl, OW'(base[w] + k)};
      else              exp = {1'b1, 1'b0, 1'b0, 1'b0, lvl, OW'(32'h29)};
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL burst c=%0d: got %h expected %h", c, got, exp); end
    end
  endtask

  task automatic test_push_pop;
    logic [OW+5:0] got, exp;
    logic [1:0] lvl;
    int base [3];
    int w, k;
    base = '{32'h40, 32'h50, 32'h60};
    apply_reset();
    for (int c = 0; c <= 31; c++) begin
      i_valid = (c == 0) || (c == 1) || (c == 11);
      i_lane  = mk(base[(c == 0) ? 0 : (c == 1) ? 1 : 2]);
      i_sync  = 1'b0;
      #1;
      if (c == 11) begin
        n_tests++;
        if ({o_ready, o_level} !== 3'b110) begin
          n_fail++; $display("FAIL push_pop ready/level: got %b/%0d expected 1/2", o_ready, o_level);
        end
      end
      @(posedge clk); #1;
      w = (c - 1) / 10; k = (c - 1) % 10;
      lvl = (c == 0) ? 2'd1 : (c <= 20) ? 2'd2 : (c <= 30) ? 2'd1 : 2'd0;
      if (c == 0)       exp = {1'b0, 1'b0, 1'b0, 1'b0, lvl, OW'(0)};
      else if (c <= 30) exp = {1'b0, 1'b1, (k == 0), 1'b0, lvl, OW'(base[w] + k)};
      else              exp = {1'b0, 1'b0, 1'b0, 1'b0, lvl, OW'(32'h69)};
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL push_pop c=%0d: got %h expected %h", c, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    logic [OW+5:0] got;
    apply_reset();
    for (int c = 0; c <= 5; c++) begin
      i_valid = (c == 0); i_lane = mk(32'h70); i_sync = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++;
    if ({o_valid, o_data} !== {1'b1, OW'(32'h74)}) begin
      n_fail++; $display("FAIL reset_mid pre: got %b/%h expected 1/74", o_valid, o_data);
    end
    #1 rst = 1'b1;
    #1;
    got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_mid async: got %h expected 0", got); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_mid resume c=%0d: got %h expected 0", c, got); end
    end
  endtask

  task automatic test_sync_off;
    logic [OW+5:0] got, exp;
    for (int c = 0; c <= 11; c++) begin
      i_valid = (c == 0); i_lane = mk(32'h80); i_sync = 1'b0;
      @(posedge clk); #1;
      if (c == 0)       exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd1, OW'(0)};
      else if (c <= 10) exp = {1'b0, 1'b1, (c == 1), 1'b0, 2'd1, OW'(32'h80 + c - 1)};
      else              exp = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, OW'(32'h89)};
      got = {o_overflow, o_valid, o_sof, o_sync, o_level, o_data};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sync_off c=%0d: got %h expected %h", c, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst_fill();
    test_push_pop();
    test_reset_mid();
    test_sync_off();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
